// File: rtl/u_datapath_sequencer_pkg.sv
// Shared types and constants for the datapath micro-sequencer.
// Covers instruction field layout, idle control values, shift op codes and FSM states.
package u_sequencer_pkg;

  localparam int DATAWIDTH_INSTR                = 16;
  localparam int DATAWIDTH_DECODER_SELECTION    = 3;
  localparam int DATAWIDTH_MUX_SELECTION        = 3;
  localparam int DATAWIDTH_ALU_SELECTION        = 4;
  localparam int DATAWIDTH_REGSHIFTER_SELECTION = 2;

  localparam int INSTR_SHIFTOP_LO = 14;
  localparam int INSTR_ALUOP_LO   = 10;
  localparam int INSTR_SRCA_LO    = 7;
  localparam int INSTR_SRCB_LO    = 4;
  localparam int INSTR_DEST_LO    = 2;
  localparam int INSTR_COUNT_LO   = 0;

  localparam logic [2:0] DECODER_IDLE = 3'b111;
  localparam logic [2:0] MUX_IDLE     = 3'b000;
  localparam logic [3:0] ALU_IDLE     = 4'b0000;
  localparam logic [1:0] SHIFT_HOLD   = 2'b11;
  localparam logic [1:0] SHIFT_NOP    = 2'b00;
  localparam logic [1:0] SHIFT_LEFT   = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT  = 2'b10;

  typedef enum logic [2:0] {
    STATE_IDLE  = 3'd0,
    STATE_EXEC  = 3'd1,
    STATE_SHIFT = 3'd2,
    STATE_WRITE = 3'd3,
    STATE_DONE  = 3'd4
  } seqState_t;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [1:0] shiftOp;
    logic [3:0] aluOp;
    logic [2:0] srcA;
    logic [2:0] srcB;
    logic [1:0] dest;
    logic [1:0] count;
  } instr_t;

endpackage

// File: rtl/u_datapath_sequencer_if.sv
// Command/datapath bundle between the command source, the sequencer and the datapath.
// Handshake: an instruction is taken on any clock edge where Start_InLow is low while Busy is low; Start is ignored while Busy is high, and Done pulses for one cycle when the instruction retires.
interface u_datapath_sequencer_if;
  import u_sequencer_pkg::*;

  logic                                      uSequencer_Start_InLow;
  logic [DATAWIDTH_INSTR-1:0]                uSequencer_Instruction_In;
  logic                                      uSequencer_Overflow_InLow;
  logic                                      uSequencer_Carry_InLow;
  logic                                      uSequencer_Negative_InLow;
  logic                                      uSequencer_Zero_InLow;
  logic                                      uSequencer_Busy_OutHigh;
  logic                                      uSequencer_Done_OutHigh;
  logic [DATAWIDTH_DECODER_SELECTION-1:0]    uSequencer_DecoderSelectionWrite_Out;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        uSequencer_MUXSelectionBUSA_Out;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        uSequencer_MUXSelectionBUSB_Out;
  logic [DATAWIDTH_ALU_SELECTION-1:0]        uSequencer_ALUSelection_Out;
  logic                                      uSequencer_RegSHIFTERLoad_OutLow;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] uSequencer_RegSHIFTERShiftSelection_OutLow;
  logic [3:0]                                uSequencer_FlagsLatched_OutLow;
  seqState_t                                 uSequencer_State_Out;

  modport master (
    output uSequencer_Start_InLow, uSequencer_Instruction_In,
    output uSequencer_Overflow_InLow, uSequencer_Carry_InLow,
    output uSequencer_Negative_InLow, uSequencer_Zero_InLow,
    input  uSequencer_Busy_OutHigh, uSequencer_Done_OutHigh,
    input  uSequencer_DecoderSelectionWrite_Out,
    input  uSequencer_MUXSelectionBUSA_Out, uSequencer_MUXSelectionBUSB_Out,
    input  uSequencer_ALUSelection_Out, uSequencer_RegSHIFTERLoad_OutLow,
    input  uSequencer_RegSHIFTERShiftSelection_OutLow,
    input  uSequencer_FlagsLatched_OutLow, uSequencer_State_Out
  );

  modport slave (
    input  uSequencer_Start_InLow, uSequencer_Instruction_In,
    input  uSequencer_Overflow_InLow, uSequencer_Carry_InLow,
    input  uSequencer_Negative_InLow, uSequencer_Zero_InLow,
    output uSequencer_Busy_OutHigh, uSequencer_Done_OutHigh,
    output uSequencer_DecoderSelectionWrite_Out,
    output uSequencer_MUXSelectionBUSA_Out, uSequencer_MUXSelectionBUSB_Out,
    output uSequencer_ALUSelection_Out, uSequencer_RegSHIFTERLoad_OutLow,
    output uSequencer_RegSHIFTERShiftSelection_OutLow,
    output uSequencer_FlagsLatched_OutLow, uSequencer_State_Out
  );

endinterface

// File: rtl/u_datapath_sequencer_sc_seq_counter.sv
// Two-bit loadable down-counter holding the remaining shift cycles.
// Load has priority over decrement; isLast marks the final shift cycle.
module sc_seq_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [1:0] loadValue,
  output logic       isZero,
  output logic       isLast
);

  logic [1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec) begin
      count <= count - 2'd1;
    end
  end

  assign isZero = (count == 2'd0);
  assign isLast = (count == 2'd1);

endmodule

// File: rtl/u_datapath_sequencer.sv
// Micro-sequencer that steps the 8-bit datapath through EXEC, SHIFT, WRITE and DONE.
// Every control output is a register loaded with the value for the state being entered.
module u_datapath_sequencer
  import u_sequencer_pkg::*;
(
  input  logic                  uSequencer_CLOCK_50,
  input  logic                  uSequencer_Reset_InHigh,
  u_datapath_sequencer_if.slave seqBus
);

  seqState_t  state;
  instr_t     instrIn;
  logic [1:0] shiftOpReg;
  logic [1:0] destReg;
  logic [3:0] flagsReg;
  logic       busyReg;
  logic       doneReg;
  logic       loadReg;
  logic [2:0] decoderReg;
  logic [2:0] muxAReg;
  logic [2:0] muxBReg;
  logic [3:0] aluReg;
  logic [1:0] shiftSelReg;
  logic       accept;
  logic       cntDec;
  logic       cntZero;
  logic       cntLast;

  assign instrIn = instr_t'(seqBus.uSequencer_Instruction_In);
  assign accept  = (state == STATE_IDLE) && !seqBus.uSequencer_Start_InLow;
  assign cntDec  = (state == STATE_SHIFT);

  sc_seq_counter uCounter (
    .clk       (uSequencer_CLOCK_50),
    .rst       (uSequencer_Reset_InHigh),
    .load      (accept),
    .dec       (cntDec),
    .loadValue (instrIn.count),
    .isZero    (cntZero),
    .isLast    (cntLast)
  );

  always_ff @(posedge uSequencer_CLOCK_50) begin
    if (uSequencer_Reset_InHigh) begin
      state       <= STATE_IDLE;
      shiftOpReg  <= SHIFT_NOP;
      destReg     <= 2'b00;
      flagsReg    <= 4'b1111;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      decoderReg  <= DECODER_IDLE;
      muxAReg     <= MUX_IDLE;
      muxBReg     <= MUX_IDLE;
      aluReg      <= ALU_IDLE;
      loadReg     <= 1'b1;
      shiftSelReg <= SHIFT_HOLD;
    end else begin
      // Idle values unless the state being entered overrides them below.
      doneReg     <= 1'b0;
      decoderReg  <= DECODER_IDLE;
      muxAReg     <= MUX_IDLE;
      muxBReg     <= MUX_IDLE;
      aluReg      <= ALU_IDLE;
      loadReg     <= 1'b1;
      shiftSelReg <= SHIFT_HOLD;
      case (state)
        STATE_IDLE: begin
          if (accept) begin
            state      <= STATE_EXEC;
            busyReg    <= 1'b1;
            shiftOpReg <= instrIn.shiftOp;
            destReg    <= instrIn.dest;
            muxAReg    <= instrIn.srcA;
            muxBReg    <= instrIn.srcB;
            aluReg     <= instrIn.aluOp;
            loadReg    <= 1'b0;
          end
        end
        STATE_EXEC: begin
          flagsReg <= {seqBus.uSequencer_Overflow_InLow, seqBus.uSequencer_Carry_InLow,
                       seqBus.uSequencer_Negative_InLow, seqBus.uSequencer_Zero_InLow};
          if (cntZero) begin
            state      <= STATE_WRITE;
            decoderReg <= {1'b0, destReg};
          end else begin
            state       <= STATE_SHIFT;
            shiftSelReg <= shiftOpReg;
          end
        end
        STATE_SHIFT: begin
          if (cntLast) begin
            state      <= STATE_WRITE;
            decoderReg <= {1'b0, destReg};
          end else begin
            shiftSelReg <= shiftOpReg;
          end
        end
        STATE_WRITE: begin
          state   <= STATE_DONE;
          doneReg <= 1'b1;
        end
        STATE_DONE: begin
          state   <= STATE_IDLE;
          busyReg <= 1'b0;
        end
        default: begin
          state   <= STATE_IDLE;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign seqBus.uSequencer_Busy_OutHigh                    = busyReg;
  assign seqBus.uSequencer_Done_OutHigh                    = doneReg;
  assign seqBus.uSequencer_DecoderSelectionWrite_Out       = decoderReg;
  assign seqBus.uSequencer_MUXSelectionBUSA_Out            = muxAReg;
  assign seqBus.uSequencer_MUXSelectionBUSB_Out            = muxBReg;
  assign seqBus.uSequencer_ALUSelection_Out                = aluReg;
  assign seqBus.uSequencer_RegSHIFTERLoad_OutLow           = loadReg;
  assign seqBus.uSequencer_RegSHIFTERShiftSelection_OutLow = shiftSelReg;
  assign seqBus.uSequencer_FlagsLatched_OutLow             = flagsReg;
  assign seqBus.uSequencer_State_Out                       = state;

endmodule

// File: tb/tb_u_datapath_sequencer.sv
// Directed bench for u_datapath_sequencer with a small datapath stub and a write scoreboard.
module tb_u_datapath_sequencer;
  import u_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [2:0] exp_q[$];
  logic [2:0] expDec;

  u_datapath_sequencer_if seqBus ();

  u_datapath_sequencer dut (
    .uSequencer_CLOCK_50     (clk),
    .uSequencer_Reset_InHigh (rst),
    .seqBus                  (seqBus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath stub: fixed registers 4 = 9 and 5 = 15, op 0011 adds, others pass A.
  logic [7:0] regs [4];
  logic [7:0] shifter;

  function automatic logic [7:0] busSrc(input logic [2:0] sel);
    case (sel)
      3'd0: return regs[0];
      3'd1: return regs[1];
      3'd2: return regs[2];
      3'd3: return regs[3];
      3'd4: return 8'd9;
      3'd5: return 8'd15;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      regs[0] <= 8'd1;
      regs[1] <= 8'd2;
      regs[2] <= 8'd3;
      regs[3] <= 8'd4;
      shifter <= 8'd0;
    end else begin
      if (!seqBus.uSequencer_RegSHIFTERLoad_OutLow)
        shifter <= (seqBus.uSequencer_ALUSelection_Out == 4'b0011)
                   ? busSrc(seqBus.uSequencer_MUXSelectionBUSA_Out) + busSrc(seqBus.uSequencer_MUXSelectionBUSB_Out)
                   : busSrc(seqBus.uSequencer_MUXSelectionBUSA_Out);
      else if (seqBus.uSequencer_RegSHIFTERShiftSelection_OutLow == SHIFT_LEFT)
        shifter <= shifter << 1;
      else if (seqBus.uSequencer_RegSHIFTERShiftSelection_OutLow == SHIFT_RIGHT)
        shifter <= shifter >> 1;
      if (seqBus.uSequencer_DecoderSelectionWrite_Out != DECODER_IDLE)
        regs[seqBus.uSequencer_DecoderSelectionWrite_Out[1:0]] <= shifter;
    end
  end

  // Scoreboard: every non-idle decoder cycle must match the next expected destination.
  always @(negedge clk) begin
    if (!rst && seqBus.uSequencer_DecoderSelectionWrite_Out != DECODER_IDLE) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%0h expected=no_write",
               seqBus.uSequencer_DecoderSelectionWrite_Out);
      end
      if (exp_q.size() != 0) begin
        expDec = exp_q.pop_front();
        checks++;
        assert (seqBus.uSequencer_DecoderSelectionWrite_Out === expDec) else begin
          failures++;
          $error("FAIL write_dest observed=%0h expected=%0h",
                 seqBus.uSequencer_DecoderSelectionWrite_Out, expDec);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic setFlags(input logic [3:0] f);
    seqBus.uSequencer_Overflow_InLow = f[3];
    seqBus.uSequencer_Carry_InLow    = f[2];
    seqBus.uSequencer_Negative_InLow = f[1];
    seqBus.uSequencer_Zero_InLow     = f[0];
  endtask

  task automatic startInstr(input logic [15:0] instr, input bit expectWrite);
    seqBus.uSequencer_Start_InLow    = 1'b0;
    seqBus.uSequencer_Instruction_In = instr;
    if (expectWrite) exp_q.push_back({1'b0, instr[3:2]});
  endtask

  task automatic releaseStart();
    seqBus.uSequencer_Start_InLow    = 1'b1;
    seqBus.uSequencer_Instruction_In = 16'($urandom_range(0, 65535));
  endtask

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutputs(input string tag, input seqState_t st, input logic busy,
                              input logic done, input logic [2:0] dec, input logic [2:0] a,
                              input logic [2:0] b, input logic [3:0] alu, input logic load,
                              input logic [1:0] shiftSel);
    checkVal({tag, ".state"}, 16'(seqBus.uSequencer_State_Out), 16'(st));
    checkVal({tag, ".busy"}, 16'(seqBus.uSequencer_Busy_OutHigh), 16'(busy));
    checkVal({tag, ".done"}, 16'(seqBus.uSequencer_Done_OutHigh), 16'(done));
    checkVal({tag, ".dec"}, 16'(seqBus.uSequencer_DecoderSelectionWrite_Out), 16'(dec));
    checkVal({tag, ".muxA"}, 16'(seqBus.uSequencer_MUXSelectionBUSA_Out), 16'(a));
    checkVal({tag, ".muxB"}, 16'(seqBus.uSequencer_MUXSelectionBUSB_Out), 16'(b));
    checkVal({tag, ".alu"}, 16'(seqBus.uSequencer_ALUSelection_Out), 16'(alu));
    checkVal({tag, ".load"}, 16'(seqBus.uSequencer_RegSHIFTERLoad_OutLow), 16'(load));
    checkVal({tag, ".shift"}, 16'(seqBus.uSequencer_RegSHIFTERShiftSelection_OutLow), 16'(shiftSel));
  endtask

  task automatic checkIdle(input string tag);
    checkOutputs(tag, STATE_IDLE, 1'b0, 1'b0, 3'b111, 3'd0, 3'd0, 4'd0, 1'b1, 2'b11);
  endtask

  task automatic checkFlags(input string tag, input logic [3:0] exp);
    checkVal(tag, 16'(seqBus.uSequencer_FlagsLatched_OutLow), 16'(exp));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    seqBus.uSequencer_Start_InLow    = 1'b1;
    seqBus.uSequencer_Instruction_In = 16'h0000;
    setFlags(4'b1111);
    step(); step();
    checkIdle("reset");
    checkFlags("reset.flags", 4'b1111);
    rst = 1'b0;
    step();
    checkIdle("post_reset");

    // 16'h4E5E: A=4 B=5 ALU=3, two left shifts, dest 3; Zero low only in EXEC.
    startInstr(16'h4E5E, 1'b1);
    step();
    releaseStart();
    setFlags(4'b1110);
    checkOutputs("i4e5e.exec", STATE_EXEC, 1, 0, 3'b111, 3'd4, 3'd5, 4'b0011, 0, 2'b11);
    step();
    setFlags(4'b0111);
    checkOutputs("i4e5e.shift1", STATE_SHIFT, 1, 0, 3'b111, 3'd0, 3'd0, 4'd0, 1, 2'b01);
    checkFlags("i4e5e.flags_shift1", 4'b1110);
    step();
    setFlags(4'b1111);
    checkOutputs("i4e5e.shift2", STATE_SHIFT, 1, 0, 3'b111, 3'd0, 3'd0, 4'd0, 1, 2'b01);
    checkFlags("i4e5e.flags_shift2", 4'b1110);
    step();
    checkOutputs("i4e5e.write", STATE_WRITE, 1, 0, 3'b011, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    step();
    checkOutputs("i4e5e.done", STATE_DONE, 1, 1, 3'b111, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    checkFlags("i4e5e.flags_done", 4'b1110);
    step();
    checkIdle("i4e5e.idle");
    checkFlags("i4e5e.flags_idle", 4'b1110);

    // 16'h0C14 with zero count, Start held low across busy: 16'h4E5E taken only back in IDLE.
    startInstr(16'h0C14, 1'b1);
    step();
    startInstr(16'h4E5E, 1'b1);
    checkOutputs("i0c14.exec", STATE_EXEC, 1, 0, 3'b111, 3'd0, 3'd1, 4'b0011, 0, 2'b11);
    step();
    checkOutputs("i0c14.write", STATE_WRITE, 1, 0, 3'b001, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    checkFlags("i0c14.flags_write", 4'b1111);
    step();
    checkOutputs("i0c14.done", STATE_DONE, 1, 1, 3'b111, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    step();
    checkIdle("i0c14.idle");
    step();
    releaseStart();
    setFlags(4'b1011);
    checkOutputs("b2b.exec", STATE_EXEC, 1, 0, 3'b111, 3'd4, 3'd5, 4'b0011, 0, 2'b11);
    step();
    setFlags(4'b1111);
    seqBus.uSequencer_Start_InLow = 1'b0;
    checkOutputs("b2b.shift1", STATE_SHIFT, 1, 0, 3'b111, 3'd0, 3'd0, 4'd0, 1, 2'b01);
    checkFlags("b2b.flags", 4'b1011);
    step();
    seqBus.uSequencer_Start_InLow = 1'b1;
    checkOutputs("b2b.shift2_start_ignored", STATE_SHIFT, 1, 0, 3'b111, 3'd0, 3'd0, 4'd0, 1, 2'b01);
    step();
    checkOutputs("b2b.write", STATE_WRITE, 1, 0, 3'b011, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    step();
    checkOutputs("b2b.done", STATE_DONE, 1, 1, 3'b111, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    step();
    checkIdle("b2b.idle");

    // 16'h8533: right shift, count 3 (maximum), A=2 B=3 ALU=1, dest 0.
    startInstr(16'h8533, 1'b1);
    step();
    releaseStart();
    checkOutputs("i8533.exec", STATE_EXEC, 1, 0, 3'b111, 3'd2, 3'd3, 4'b0001, 0, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutputs($sformatf("i8533.shift%0d", i + 1), STATE_SHIFT, 1, 0, 3'b111,
                   3'd0, 3'd0, 4'd0, 1, 2'b10);
    end
    step();
    checkOutputs("i8533.write", STATE_WRITE, 1, 0, 3'b000, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    step();
    checkOutputs("i8533.done", STATE_DONE, 1, 1, 3'b111, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    step();
    checkIdle("i8533.idle");

    // Reset during SHIFT aborts: no write and flags return to 1111.
    startInstr(16'h4E5E, 1'b0);
    step();
    releaseStart();
    setFlags(4'b1110);
    step();
    setFlags(4'b1111);
    checkFlags("abort.flags_before", 4'b1110);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkIdle("abort.reset");
    checkFlags("abort.flags", 4'b1111);
    for (int i = 0; i < 4; i++) begin
      step();
      checkIdle($sformatf("abort.after%0d", i));
    end

    // Datapath integration: 16'h0E5C = A 4 (9) + B 5 (15), dest 3, no shift.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    startInstr(16'h0E5C, 1'b1);
    step();
    releaseStart();
    step();
    checkOutputs("integ.write", STATE_WRITE, 1, 0, 3'b011, 3'd0, 3'd0, 4'd0, 1, 2'b11);
    checkVal("integ.r3_before", 16'(regs[3]), 16'd4);
    step();
    checkVal("integ.r3", 16'(regs[3]), 16'h18);
    checkVal("integ.r0", 16'(regs[0]), 16'd1);
    checkVal("integ.r1", 16'(regs[1]), 16'd2);
    checkVal("integ.r2", 16'(regs[2]), 16'd3);
    step();
    checkIdle("integ.idle");

    checkVal("scoreboard.pending", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
